// File: rtl/req_gnt_mon_pkg.sv
// Shared types and helpers for the req/gnt protocol monitor.
package req_gnt_mon_pkg;

  typedef enum logic {IDLE, WAIT} lane_state_t;

  typedef enum logic [1:0] {EV_NONE, EV_PASS, EV_FAIL, EV_VAC} lane_ev_t;

  // $clog2 clamped to at least one bit, for latency counters and channel indices.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/req_gnt_lane.sv
// One req/gnt channel: classifies each sampled edge and tracks the open grant window.
module req_gnt_lane
  import req_gnt_mon_pkg::*;
#(
  parameter int unsigned MAX_LAT = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  logic     clr,
  input  logic     req,
  input  logic     gnt,
  output lane_ev_t ev
);

  localparam int unsigned LatW = clog2_min1(MAX_LAT + 1);

  lane_state_t     state_q;
  logic [LatW-1:0] lat_q;

  // Event decided by the upcoming edge; the top level registers it.
  always_comb begin
    ev = EV_NONE;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (gnt)               ev = EV_PASS;
          else if (MAX_LAT == 0) ev = EV_FAIL;
        end else begin
          ev = EV_VAC;
        end
      end
      WAIT: begin
        if (gnt)                        ev = EV_PASS;
        else if (lat_q == LatW'(MAX_LAT)) ev = EV_FAIL;
      end
      default: ev = EV_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
    end else if (clr) begin
      state_q <= IDLE;
      lat_q   <= '0;
    end else if (en) begin
      unique case (state_q)
        IDLE: begin
          if (req && ev == EV_NONE) begin
            state_q <= WAIT;
            lat_q   <= LatW'(1);
          end
        end
        WAIT: begin
          if (ev != EV_NONE) begin
            state_q <= IDLE;
            lat_q   <= '0;
          end else begin
            lat_q <= lat_q + LatW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          lat_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/req_gnt_monitor.sv
// Multi-channel req/gnt monitor: per-channel lanes feeding saturating event counters,
// registered pulses and a sticky first-failure record.
module req_gnt_monitor
  import req_gnt_mon_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned MAX_LAT = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic                               clr,
  input  logic                               vac_off,
  input  logic [NCH-1:0]                     req,
  input  logic [NCH-1:0]                     gnt,
  output logic [NCH-1:0]                     pass_pulse,
  output logic [NCH-1:0]                     fail_pulse,
  output logic [NCH*CNT_W-1:0]               pass_cnt,
  output logic [NCH*CNT_W-1:0]               fail_cnt,
  output logic [NCH*CNT_W-1:0]               vac_cnt,
  output logic                               err_sticky,
  output logic [clog2_min1(NCH)-1:0]         first_fail_ch
);

  localparam int unsigned IdxW = clog2_min1(NCH);

  lane_ev_t             ev [NCH];
  logic [NCH-1:0]       fail_vec;
  logic [IdxW-1:0]      fail_idx;

  logic [NCH-1:0]       pass_pulse_q, fail_pulse_q;
  logic [CNT_W-1:0]     pass_q [NCH];
  logic [CNT_W-1:0]     fail_q [NCH];
  logic [CNT_W-1:0]     vac_q  [NCH];
  logic                 err_q;
  logic [IdxW-1:0]      first_q;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    req_gnt_lane #(
      .MAX_LAT (MAX_LAT)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .clr   (clr),
      .req   (req[g]),
      .gnt   (gnt[g]),
      .ev    (ev[g])
    );

    assign fail_vec[g]                 = (ev[g] == EV_FAIL);
    assign pass_cnt[g*CNT_W +: CNT_W]  = pass_q[g];
    assign fail_cnt[g*CNT_W +: CNT_W]  = fail_q[g];
    assign vac_cnt[g*CNT_W +: CNT_W]   = vac_q[g];
  end

  // Scan high to low so the lowest failing channel wins.
  always_comb begin
    fail_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (fail_vec[i]) fail_idx = IdxW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_pulse_q <= '0;
      fail_pulse_q <= '0;
      err_q        <= 1'b0;
      first_q      <= '0;
      for (int i = 0; i < NCH; i++) begin
        pass_q[i] <= '0;
        fail_q[i] <= '0;
        vac_q[i]  <= '0;
      end
    end else if (clr) begin
      pass_pulse_q <= '0;
      fail_pulse_q <= '0;
      err_q        <= 1'b0;
      first_q      <= '0;
      for (int i = 0; i < NCH; i++) begin
        pass_q[i] <= '0;
        fail_q[i] <= '0;
        vac_q[i]  <= '0;
      end
    end else if (!en) begin
      pass_pulse_q <= '0;
      fail_pulse_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        pass_pulse_q[i] <= (ev[i] == EV_PASS);
        fail_pulse_q[i] <= (ev[i] == EV_FAIL);
        if (ev[i] == EV_PASS && pass_q[i] != '1) pass_q[i] <= pass_q[i] + CNT_W'(1);
        if (ev[i] == EV_FAIL && fail_q[i] != '1) fail_q[i] <= fail_q[i] + CNT_W'(1);
        if (ev[i] == EV_VAC && !vac_off && vac_q[i] != '1) vac_q[i] <= vac_q[i] + CNT_W'(1);
      end
      if (!err_q && |fail_vec) begin
        err_q   <= 1'b1;
        first_q <= fail_idx;
      end
    end
  end

  assign pass_pulse    = pass_pulse_q;
  assign fail_pulse    = fail_pulse_q;
  assign err_sticky    = err_q;
  assign first_fail_ch = first_q;

endmodule
